// File: rtl/sme_job_feeder.sv
// sme_job_feeder: buffers one string/pattern job from a byte stream, replays it
// to the string matching engine as isstring/ispattern bursts aligned to the
// engine's valid pulse, and returns the engine's verdict on a result handshake.
// Optional build macro: SME_FEEDER_TIMEOUT_EN adds a watchdog on ARM/WAIT_RES.
module sme_job_feeder #(
    parameter int STR_MAX     = 32,
    parameter int PAT_MAX     = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_kind,
    input  logic       in_last,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_error
);
    // Pointers/lengths need one extra bit so they can hold the full depth.
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);

    localparam logic [2:0] COLLECT  = 3'd0;
    localparam logic [2:0] ARM      = 3'd1;
    localparam logic [2:0] SEND_S   = 3'd2;
    localparam logic [2:0] SEND_P   = 3'd3;
    localparam logic [2:0] WAIT_RES = 3'd4;
    localparam logic [2:0] OUT      = 3'd5;

    logic [2:0]    state;
    logic [7:0]    sbuf [STR_MAX];
    logic [7:0]    pbuf [PAT_MAX];
    logic [SW-1:0] s_ptr, s_len, idx;
    logic [PW-1:0] p_ptr, p_len;
    logic          str_pending, str_loaded, ovf;
    logic          launch, job_bad, wd_fire;

    assign in_ready      = (state == COLLECT);
    assign res_valid     = (state == OUT);
    // First string byte goes out in the very cycle the engine pulses valid.
    assign launch        = (state == ARM) && sme_valid && !ovf && str_pending;
    assign job_bad       = ovf || (!str_pending && !str_loaded);
    assign sme_isstring  = (state == SEND_S) || launch;
    assign sme_ispattern = (state == SEND_P);

`ifdef SME_FEEDER_TIMEOUT_EN
    logic [7:0] wdog;

    // Watchdog: runs from job arm until the result is captured; sme_valid wins a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog <= 8'd0;
        else if (state == COLLECT || state == OUT)
            wdog <= 8'd0;
        else if (state == ARM || state == WAIT_RES)
            wdog <= wdog + 8'd1;
    end

    assign wd_fire = (state == ARM || state == WAIT_RES) && !sme_valid &&
                     (wdog == 8'(TIMEOUT_CYC - 1));
`else
    assign wd_fire = 1'b0;
`endif

    // Byte buffers are plain storage; reset leaves their contents alone.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready && !in_kind && s_ptr < SW'(STR_MAX))
            sbuf[s_ptr[SAW-1:0]] <= in_data;
        if (in_valid && in_ready && in_kind && p_ptr < PW'(PAT_MAX))
            pbuf[p_ptr[PAW-1:0]] <= in_data;
    end

    // Engine data mux: string byte 0 on launch, otherwise the active burst byte.
    always_comb begin
        sme_chardata = 8'd0;
        if (launch)
            sme_chardata = sbuf[0];
        else if (state == SEND_S)
            sme_chardata = sbuf[idx[SAW-1:0]];
        else if (state == SEND_P)
            sme_chardata = pbuf[idx[PAW-1:0]];
    end

    // Job control FSM: collect, arm, string burst, pattern burst, wait, result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            s_ptr       <= '0;
            p_ptr       <= '0;
            s_len       <= '0;
            p_len       <= '0;
            idx         <= '0;
            str_pending <= 1'b0;
            str_loaded  <= 1'b0;
            ovf         <= 1'b0;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_error   <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (in_valid) begin
                    if (!in_kind) begin
                        if (s_ptr >= SW'(STR_MAX)) ovf <= 1'b1;
                        if (in_last) begin
                            s_len       <= (s_ptr >= SW'(STR_MAX)) ? SW'(STR_MAX) : s_ptr + SW'(1);
                            str_pending <= 1'b1;
                            s_ptr       <= '0;   // a following string starts over
                        end else if (s_ptr < SW'(STR_MAX)) begin
                            s_ptr <= s_ptr + SW'(1);
                        end
                    end else begin
                        if (p_ptr >= PW'(PAT_MAX)) ovf <= 1'b1;
                        if (in_last) begin
                            p_len <= (p_ptr >= PW'(PAT_MAX)) ? PW'(PAT_MAX) : p_ptr + PW'(1);
                            state <= ARM;
                        end else if (p_ptr < PW'(PAT_MAX)) begin
                            p_ptr <= p_ptr + PW'(1);
                        end
                    end
                end
                ARM: if (sme_valid) begin
                    if (job_bad) begin
                        // Nothing usable to send: report failure without touching the engine.
                        res_error <= 1'b1;
                        res_match <= 1'b0;
                        res_index <= 5'd0;
                        state     <= OUT;
                    end else if (str_pending) begin
                        idx   <= (s_len == SW'(1)) ? SW'(0) : SW'(1);
                        state <= (s_len == SW'(1)) ? SEND_P : SEND_S;
                    end else begin
                        idx   <= '0;
                        state <= SEND_P;
                    end
                end else if (wd_fire) begin
                    res_error  <= 1'b1;
                    res_match  <= 1'b0;
                    res_index  <= 5'd0;
                    str_loaded <= 1'b0;
                    state      <= OUT;
                end
                SEND_S: begin
                    if (idx == s_len - SW'(1)) begin
                        idx   <= '0;
                        state <= SEND_P;
                    end else begin
                        idx <= idx + SW'(1);
                    end
                end
                SEND_P: begin
                    if (idx == SW'(p_len) - SW'(1)) begin
                        str_loaded  <= 1'b1;
                        str_pending <= 1'b0;
                        state       <= WAIT_RES;
                    end else begin
                        idx <= idx + SW'(1);
                    end
                end
                WAIT_RES: if (sme_valid) begin
                    res_match <= sme_match;
                    res_index <= sme_match_index;
                    res_error <= 1'b0;
                    state     <= OUT;
                end else if (wd_fire) begin
                    res_error  <= 1'b1;
                    res_match  <= 1'b0;
                    res_index  <= 5'd0;
                    str_loaded <= 1'b0;
                    state      <= OUT;
                end
                OUT: if (res_ready) begin
                    s_ptr <= '0;
                    p_ptr <= '0;
                    ovf   <= 1'b0;
                    state <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_sme_job_feeder.sv
// Bench for sme_job_feeder: queue-based job model checked every cycle, plus
// hand-computed literal expectations per directed job.
module tb_sme_job_feeder;
    localparam int STR_MAX     = 32;
    localparam int PAT_MAX     = 8;
    localparam int TIMEOUT_CYC = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_kind = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic [7:0] sme_chardata;
    logic       sme_isstring, sme_ispattern;
    logic       sme_valid = 1'b0, sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic       res_valid, res_ready = 1'b0, res_match, res_error;
    logic [4:0] res_index;

    always #5 clk = ~clk;

    sme_job_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_last(in_last),
        .sme_chardata(sme_chardata), .sme_isstring(sme_isstring),
        .sme_ispattern(sme_ispattern), .sme_valid(sme_valid),
        .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
        .res_index(res_index), .res_error(res_error)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endfunction

    // Engine stand-in: free-running valid pulse every 5 cycles.
    logic eng_en = 1'b1;
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk); #1;
            cnt++;
            sme_valid = eng_en && (cnt % 5 == 0);
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef enum {P_COLLECT, P_ARMED, P_BURST, P_WAITRES, P_RESULT} ph_t;
    ph_t        ph = P_COLLECT;
    logic [7:0] m_cur[$], m_pcur[$], m_str[$], m_pat[$];
    logic [9:0] m_burst[$];          // {isstring, ispattern, data}
    logic       m_spend = 0, m_loaded = 0, m_ovf = 0;
    logic       m_match = 0, m_err = 0;
    logic [4:0] m_index = 0;
    int         wd = 0;
    int         n_isstr = 0, n_ispat = 0;
    logic       prev_isstr = 0, str_rise_valid = 0;

    initial begin
        logic       e_s, e_p;
        logic [7:0] e_d;
        logic       tmo;
        forever begin
            @(negedge clk);
            if (reset) begin
                ph = P_COLLECT; m_cur.delete(); m_pcur.delete(); m_burst.delete();
                m_spend = 0; m_loaded = 0; m_ovf = 0;
                m_match = 0; m_err = 0; m_index = 0; wd = 0;
            end
            e_s = 0; e_p = 0; e_d = 8'd0;
            if (ph == P_BURST && m_burst.size() > 0)
                {e_s, e_p, e_d} = m_burst[0];
            else if (ph == P_ARMED && sme_valid && !m_ovf && m_spend) begin
                e_s = 1; e_d = m_str[0];
            end
            chk("in_ready", int'(in_ready), int'(ph == P_COLLECT));
            chk("res_valid", int'(res_valid), int'(ph == P_RESULT));
            chk("isstring", int'(sme_isstring), int'(e_s));
            chk("ispattern", int'(sme_ispattern), int'(e_p));
            chk("chardata", int'(sme_chardata), int'(e_d));
            chk("res_match", int'(res_match), int'(m_match));
            chk("res_index", int'(res_index), int'(m_index));
            chk("res_error", int'(res_error), int'(m_err));

            if (sme_isstring && !prev_isstr) str_rise_valid = sme_valid;
            prev_isstr = sme_isstring;
            if (sme_isstring) n_isstr++;
            if (sme_ispattern) n_ispat++;

`ifdef SME_FEEDER_TIMEOUT_EN
            tmo = !sme_valid && (wd == TIMEOUT_CYC - 1);
`else
            tmo = 1'b0;
`endif
            if (!reset) begin
                case (ph)
                    P_COLLECT: begin
                        wd = 0;
                        if (in_valid) begin
                            if (!in_kind) begin
                                if (m_cur.size() < STR_MAX) m_cur.push_back(in_data); else m_ovf = 1;
                                if (in_last) begin m_str = m_cur; m_cur.delete(); m_spend = 1; end
                            end else begin
                                if (m_pcur.size() < PAT_MAX) m_pcur.push_back(in_data); else m_ovf = 1;
                                if (in_last) begin m_pat = m_pcur; ph = P_ARMED; end
                            end
                        end
                    end
                    P_ARMED: begin
                        if (sme_valid) begin
                            if (m_ovf || (!m_spend && !m_loaded)) begin
                                m_match = 0; m_index = 0; m_err = 1; ph = P_RESULT;
                            end else begin
                                m_burst.delete();
                                if (m_spend)
                                    for (int i = 1; i < m_str.size(); i++) m_burst.push_back({2'b10, m_str[i]});
                                foreach (m_pat[i]) m_burst.push_back({2'b01, m_pat[i]});
                                ph = P_BURST;
                            end
                        end else if (tmo) begin
                            m_match = 0; m_index = 0; m_err = 1; m_loaded = 0; ph = P_RESULT;
                        end
                        wd++;
                    end
                    P_BURST: begin
                        void'(m_burst.pop_front());
                        if (m_burst.size() == 0) begin
                            m_loaded = 1; m_spend = 0; ph = P_WAITRES;
                        end
                    end
                    P_WAITRES: begin
                        if (sme_valid) begin
                            m_match = sme_match; m_index = sme_match_index; m_err = 0; ph = P_RESULT;
                        end else if (tmo) begin
                            m_match = 0; m_index = 0; m_err = 1; m_loaded = 0; ph = P_RESULT;
                        end
                        wd++;
                    end
                    P_RESULT: if (res_ready) begin
                        ph = P_COLLECT; m_ovf = 0; m_cur.delete(); m_pcur.delete();
                    end
                    default: ph = P_COLLECT;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic kind, input logic [7:0] d, input logic last);
        bit done = 0;
        in_valid = 1; in_kind = kind; in_data = d; in_last = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) chk("send_bound", 0, 1);
        in_valid = 0; in_last = 0;
    endtask

    task automatic send_str(input logic kind, input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(kind, s[i], i == s.len() - 1);
    endtask

    task automatic wait_res(output logic m, output logic [4:0] ix, output logic e);
        bit got = 0;
        m = 0; ix = 0; e = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (res_valid) begin got = 1; m = res_match; ix = res_index; e = res_error; end
            @(posedge clk); #1;
        end
        if (!got) chk("result_bound", 0, 1);
    endtask

    task automatic accept_res();
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
    endtask

    // ---------------- directed jobs ----------------
    initial begin
        logic       m, e;
        logic [4:0] ix;
        int         bs, bp, cyc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_isstring", int'(sme_isstring), 0);
        reset = 0;

        // Job 1: "ab c" + "c", engine says match at 3.
        sme_match = 1; sme_match_index = 5'd3;
        bs = n_isstr; bp = n_ispat;
        send_str(0, "ab c"); send_str(1, "c");
        wait_res(m, ix, e);
        chk("j1_match", int'(m), 1); chk("j1_index", int'(ix), 3); chk("j1_error", int'(e), 0);
        chk("j1_isstr_cycles", n_isstr - bs, 4); chk("j1_ispat_cycles", n_ispat - bp, 1);
        chk("j1_start_on_valid", int'(str_rise_valid), 1);
        accept_res();

        // Job 2: pattern-only "ab" reusing loaded string; then hold the result.
        sme_match = 1; sme_match_index = 5'd0;
        bs = n_isstr; bp = n_ispat;
        send_str(1, "ab");
        wait_res(m, ix, e);
        sme_match = 0; sme_match_index = 5'd17;   // later engine activity must not leak into the result
        chk("j2_match", int'(m), 1); chk("j2_index", int'(ix), 0); chk("j2_error", int'(e), 0);
        chk("j2_isstr_cycles", n_isstr - bs, 0); chk("j2_ispat_cycles", n_ispat - bp, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(res_valid), 1); chk("hold_index", int'(res_index), 0);
            chk("hold_match", int'(res_match), 1); chk("hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        accept_res();
        @(negedge clk); chk("in_ready_after_accept", int'(in_ready), 1);
        @(posedge clk); #1;

        // Job 3: single-byte string "z" + "zz".
        sme_match = 0; sme_match_index = 5'd0;
        bs = n_isstr; bp = n_ispat;
        send_str(0, "z"); send_str(1, "zz");
        wait_res(m, ix, e);
        chk("j3_match", int'(m), 0); chk("j3_error", int'(e), 0);
        chk("j3_isstr_cycles", n_isstr - bs, 1); chk("j3_ispat_cycles", n_ispat - bp, 2);
        accept_res();

        // Job 4: full 8-byte pattern, then a 9-byte pattern that overflows.
        sme_match = 1; sme_match_index = 5'd9;
        bp = n_ispat;
        send_str(1, "abcdefgh");
        wait_res(m, ix, e);
        chk("j4_error", int'(e), 0); chk("j4_index", int'(ix), 9);
        chk("j4_ispat_cycles", n_ispat - bp, 8);
        accept_res();
        bs = n_isstr; bp = n_ispat;
        send_str(1, "abcdefghi");
        wait_res(m, ix, e);
        chk("p_ovf_error", int'(e), 1); chk("p_ovf_match", int'(m), 0);
        chk("p_ovf_traffic", (n_isstr - bs) + (n_ispat - bp), 0);
        accept_res();

        // Job 5: pattern-only straight after reset -> error, engine untouched.
        do_reset();
        bs = n_isstr; bp = n_ispat;
        send_str(1, "x");
        wait_res(m, ix, e);
        chk("nostr_error", int'(e), 1); chk("nostr_index", int'(ix), 0);
        chk("nostr_traffic", (n_isstr - bs) + (n_ispat - bp), 0);
        accept_res();

        // Job 6: 33-byte string overflows.
        do_reset();
        bs = n_isstr; bp = n_ispat;
        for (int i = 0; i < 33; i++) send_byte(0, 8'(8'h41 + i % 26), i == 32);
        send_str(1, "a");
        wait_res(m, ix, e);
        chk("s_ovf_error", int'(e), 1);
        chk("s_ovf_isstring", n_isstr - bs, 0); chk("s_ovf_ispattern", n_ispat - bp, 0);
        accept_res();

`ifdef SME_FEEDER_TIMEOUT_EN
        // Job 7: engine silent -> watchdog error 255 cycles after arming.
        do_reset();
        eng_en = 0;
        send_str(0, "q"); send_str(1, "q");
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (res_valid) break;
            cyc++;
            @(posedge clk); #1;
        end
        chk("wd_cycles", cyc, 255);
        chk("wd_error", int'(res_error), 1);
        @(posedge clk); #1;
        accept_res();
        eng_en = 1;
`else
        cyc = 0;
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
